// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter with one holding byte in front of the shift register.
// TXDATA at word 0, STATUS {overrun, hold_full, busy} at word 1; TXD idles high.
module uart_tx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned IO_BIT       = 22
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        TXD
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [2:0]        idx, idx_n;
  logic [7:0]        shifter, shifter_n;
  logic [7:0]        hold, hold_n;
  logic              hold_full, hold_full_n;
  logic              overrun, overrun_n;
  logic              txd, txd_n;
  logic [31:0]       rdata_n;

  logic              sel_c, wr_tx_c, clr_c, rd_c, bit_end_c, load_c, accept_c, busy_c;
  logic [1:0]        offset_c;
  logic              unused_bits;

  assign sel_c     = mem_addr[IO_BIT];
  assign offset_c  = mem_addr[3:2];
  assign wr_tx_c   = sel_c & mem_wmask[0] & (offset_c == 2'd0);
  assign clr_c     = sel_c & mem_wmask[0] & (offset_c == 2'd1) & mem_wdata[2];
  assign rd_c      = sel_c & mem_rstrb;
  assign bit_end_c = (cnt == CNT_MAX);
  assign busy_c    = (state != IDLE);
  assign unused_bits = ^{mem_addr, mem_wdata, mem_wmask};

  // Next-state, datapath and bus-side updates; every register output is computed here.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shifter_n = shifter;
    txd_n     = txd;
    load_c    = 1'b0;
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        cnt_n = '0;
        if (hold_full) begin
          load_c    = 1'b1;
          shifter_n = hold;
          txd_n     = 1'b0;
          state_n   = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          cnt_n   = '0;
          idx_n   = 3'd0;
          txd_n   = shifter[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          cnt_n = '0;
          if (idx != 3'd7) begin
            shifter_n = {1'b0, shifter[7:1]};
            txd_n     = shifter[1];
            idx_n     = idx + 3'd1;
          end else begin
            txd_n   = 1'b1;
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          cnt_n = '0;
          // Chain straight into the next start bit when a byte is waiting.
          if (hold_full) begin
            load_c    = 1'b1;
            shifter_n = hold;
            txd_n     = 1'b0;
            state_n   = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
        cnt_n   = '0;
      end
    endcase

    // A write into a full holding register is still taken if the shifter drains it this cycle.
    accept_c    = wr_tx_c & (~hold_full | load_c);
    hold_n      = accept_c ? mem_wdata[7:0] : hold;
    hold_full_n = accept_c ? 1'b1 : (load_c ? 1'b0 : hold_full);
    overrun_n   = (wr_tx_c & ~accept_c) ? 1'b1 : (clr_c ? 1'b0 : overrun);

    rdata_n = mem_rdata;
    if (rd_c) begin
      rdata_n = (offset_c == 2'd1) ? {29'd0, overrun, hold_full, busy_c} : 32'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shifter   <= 8'd0;
      hold      <= 8'd0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
      txd       <= 1'b1;
      mem_rdata <= 32'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shifter   <= shifter_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      overrun   <= overrun_n;
      txd       <= txd_n;
      mem_rdata <= rdata_n;
    end
  end

  assign TXD = txd;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at 4 clocks per bit: register map, frame timing,
// double buffering, overrun, mid-frame reset and address decode.
module tb_uart_tx_mmio;

  localparam logic [31:0] A_TX = 32'h0040_0000;
  localparam logic [31:0] A_ST = 32'h0040_0004;
  localparam logic [31:0] A_R2 = 32'h0040_0008;
  localparam logic [31:0] A_R3 = 32'h0040_000C;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [3:0]  mem_wmask = 4'd0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic        txd;

  int vec = 0;
  int errs = 0;
  logic [31:0] d;

  uart_tx_mmio #(.CLKS_PER_BIT(4), .IO_BIT(22)) dut (
    .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .TXD(txd)
  );

  always #5 clk = ~clk;

  // Line receiver: samples mid-bit and queues each byte (-1 on a bad stop bit).
  int          rx_q[$];
  int          rx_ph = 0;
  logic        rx_on = 1'b0;
  logic [9:0]  rx_sh = 10'd0;
  always @(negedge clk) begin
    if (!resetn) begin
      rx_on = 1'b0;
      rx_ph = 0;
    end else if (!rx_on) begin
      if (txd === 1'b0) begin
        rx_on = 1'b1;
        rx_ph = 0;
      end
    end else begin
      rx_ph++;
      if (rx_ph % 4 == 2) rx_sh[rx_ph/4] = txd;
      if (rx_ph == 38) begin
        rx_on = 1'b0;
        if (rx_sh[9] === 1'b1) rx_q.push_back(int'(rx_sh[8:1]));
        else rx_q.push_back(-1);
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] wd);
    mem_addr  = a;
    mem_wdata = wd;
    mem_wmask = 4'hF;
    @(negedge clk);
    mem_wmask = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] rd);
    mem_addr  = a;
    mem_rstrb = 1'b1;
    @(negedge clk);
    mem_rstrb = 1'b0;
    rd = mem_rdata;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    vec++; if (txd !== 1'b1) begin errs++; $display("FAIL reset_txd: got %b expected 1", txd); end
    vec++; if (mem_rdata !== 32'd0) begin errs++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata); end
    resetn = 1'b1;
    bus_read(A_ST, d);
    vec++; if (d !== 32'd0) begin errs++; $display("FAIL reset_status: got %h expected 0", d); end
  endtask

  task automatic test_single_frame();
    logic [9:0] pat;
    pat = 10'h34A;  // 0,1,0,1,0,0,1,0,1,1 from bit 0 upward
    bus_write(A_TX, 32'h0000_00A5);
    vec++; if (txd !== 1'b1) begin errs++; $display("FAIL a5_latency: got %b expected 1", txd); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      vec++;
      if (txd !== pat[i/4]) begin
        errs++; $display("FAIL a5_bit cycle %0d: got %b expected %b", i, txd, pat[i/4]);
      end
    end
    bus_read(A_ST, d);
    vec++; if (d !== 32'h1) begin errs++; $display("FAIL a5_busy_end: got %h expected 1", d); end
    bus_read(A_ST, d);
    vec++; if (d !== 32'h0) begin errs++; $display("FAIL a5_idle: got %h expected 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] f;
    f = {1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0};
    bus_write(A_TX, 32'h0000_0055);
    bus_write(A_TX, 32'h0000_000F);
    mem_addr = A_ST;
    for (int i = 0; i < 80; i++) begin
      vec++;
      if (txd !== f[i/4]) begin
        errs++; $display("FAIL b2b_bit cycle %0d: got %b expected %b", i, txd, f[i/4]);
      end
      if (i == 21) begin
        vec++; if (mem_rdata !== 32'h3) begin errs++; $display("FAIL b2b_hold_full: got %h expected 3", mem_rdata); end
      end
      if (i == 61) begin
        vec++; if (mem_rdata !== 32'h1) begin errs++; $display("FAIL b2b_hold_empty: got %h expected 1", mem_rdata); end
      end
      mem_rstrb = (i == 20) || (i == 60);
      @(negedge clk);
    end
    mem_rstrb = 1'b0;
  endtask

  task automatic test_overrun();
    rx_q.delete();
    bus_write(A_TX, 32'h11);
    bus_write(A_TX, 32'h22);
    bus_write(A_TX, 32'h33);
    bus_read(A_ST, d);
    vec++; if (d !== 32'h7) begin errs++; $display("FAIL ovr_status: got %h expected 7", d); end
    bus_write(A_ST, 32'h4);
    bus_read(A_ST, d);
    vec++; if (d !== 32'h3) begin errs++; $display("FAIL ovr_clear: got %h expected 3", d); end
    bus_read(32'h0000_0004, d);
    vec++; if (d !== 32'h3) begin errs++; $display("FAIL unsel_read_hold: got %h expected 3", d); end
    repeat (100) @(negedge clk);
    vec++; if (rx_q.size() != 2) begin errs++; $display("FAIL ovr_frames: got %0d expected 2", rx_q.size()); end
    if (rx_q.size() >= 2) begin
      vec++; if (rx_q[0] != 32'h11) begin errs++; $display("FAIL ovr_byte0: got %h expected 11", rx_q[0]); end
      vec++; if (rx_q[1] != 32'h22) begin errs++; $display("FAIL ovr_byte1: got %h expected 22", rx_q[1]); end
    end
    bus_read(A_ST, d);
    vec++; if (d !== 32'h0) begin errs++; $display("FAIL ovr_idle: got %h expected 0", d); end
  endtask

  task automatic test_mid_reset();
    rx_q.delete();
    bus_write(A_TX, 32'hF0);
    repeat (18) @(negedge clk);
    vec++; if (txd !== 1'b0) begin errs++; $display("FAIL mr_bit3: got %b expected 0", txd); end
    resetn = 1'b0;
    @(negedge clk);
    vec++; if (txd !== 1'b1) begin errs++; $display("FAIL mr_txd: got %b expected 1", txd); end
    resetn = 1'b1;
    bus_read(A_ST, d);
    vec++; if (d !== 32'h0) begin errs++; $display("FAIL mr_status: got %h expected 0", d); end
    bus_write(A_TX, 32'h96);
    repeat (50) @(negedge clk);
    vec++; if (rx_q.size() != 1) begin errs++; $display("FAIL mr_frames: got %0d expected 1", rx_q.size()); end
    if (rx_q.size() >= 1) begin
      vec++; if (rx_q[0] != 32'h96) begin errs++; $display("FAIL mr_byte: got %h expected 96", rx_q[0]); end
    end
  endtask

  task automatic test_decode();
    rx_q.delete();
    bus_write(32'h0000_0000, 32'h77);
    bus_write(A_R2, 32'h77);
    bus_write(A_R3, 32'h77);
    for (int i = 0; i < 20; i++) begin
      vec++; if (txd !== 1'b1) begin errs++; $display("FAIL dec_txd cycle %0d: got %b expected 1", i, txd); end
      @(negedge clk);
    end
    bus_read(A_ST, d);
    vec++; if (d !== 32'h0) begin errs++; $display("FAIL dec_status: got %h expected 0", d); end
    bus_write(A_TX, 32'h01);
    bus_read(A_ST, d);
    vec++; if (d !== 32'h2) begin errs++; $display("FAIL dec_hold: got %h expected 2", d); end
    bus_read(A_R2, d);
    vec++; if (d !== 32'h0) begin errs++; $display("FAIL dec_r2_read: got %h expected 0", d); end
    repeat (45) @(negedge clk);
    vec++; if (rx_q.size() != 1) begin errs++; $display("FAIL dec_frames: got %0d expected 1", rx_q.size()); end
    if (rx_q.size() >= 1) begin
      vec++; if (rx_q[0] != 32'h01) begin errs++; $display("FAIL dec_byte: got %h expected 01", rx_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_mid_reset();
    test_decode();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
